// File: rtl/hera_mem_arbiter.sv
// hera_mem_arbiter
//   Shares the single HERA memory port between the instruction-fetch (I) and
//   load/store data (D) paths. Only one memory transaction is in flight at a
//   time. Under contention the port that did not win last time is granted.
//   A granted transaction that sees no mem_ack within TIMEOUT cycles is
//   aborted: the requester still receives its ack, together with err, and
//   reads zero data.
//
// Ports
//   clk, rst                : rising-edge clock, synchronous active-low reset
//   if_req/if_addr          : fetch request (held until if_ack)
//   if_rdata/if_ack         : fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata : load/store request (held until d_ack)
//   d_rdata/d_ack           : load data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata : memory-side request (held until ack/abort)
//   mem_rdata/mem_ack       : memory-side response
//   busy                    : high whenever the arbiter is not idle
//   err                     : one-cycle pulse together with an aborting ack
//
// Optional build macro HERA_ARB_STATS_EN
//   Adds saturating counters stat_i_cnt[15:0], stat_d_cnt[15:0] and
//   stat_to_cnt[7:0] (I acks, D acks, timeouts), cleared by reset.
module hera_mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          err
`ifdef HERA_ARB_STATS_EN
  ,
  output logic [15:0]   stat_i_cnt,
  output logic [15:0]   stat_d_cnt,
  output logic [7:0]    stat_to_cnt
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The wait counter is compared against TIMEOUT-1 before incrementing, so
  // the abort happens on the edge where it would reach TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;   // 1'b0 = I, 1'b1 = D
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
`ifdef HERA_ARB_STATS_EN
  logic [15:0]   stat_i_cnt_q, stat_i_cnt_d;
  logic [15:0]   stat_d_cnt_q, stat_d_cnt_d;
  logic [7:0]    stat_to_cnt_q, stat_to_cnt_d;
`endif

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // D wins when alone, or when both ask and I had the last grant.
        if (d_req && (!if_req || !last_grant_q)) begin
          state_d      = S_GNT_D;
          last_grant_d = 1'b1;
          cnt_d        = {CW{1'b0}};
          mem_req_d    = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
        end else if (if_req) begin
          state_d      = S_GNT_I;
          last_grant_d = 1'b0;
          cnt_d        = {CW{1'b0}};
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = {DW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GNT_I, S_GNT_D: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          if (state_q == S_GNT_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ack_d   = 1'b1;
            // Stores return zero rather than whatever the bus carried.
            d_rdata_d = mem_we_q ? {DW{1'b0}} : mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          err_d     = 1'b1;
          cnt_d     = CNT_MAX;
          if (state_q == S_GNT_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = {DW{1'b0}};
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = {DW{1'b0}};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // Turnaround cycle: lets the requester drop req after seeing ack.
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);

`ifdef HERA_ARB_STATS_EN
    if (if_ack_d && (stat_i_cnt_q != 16'hFFFF)) begin
      stat_i_cnt_d = stat_i_cnt_q + 16'd1;
    end else begin
      stat_i_cnt_d = stat_i_cnt_q;
    end
    if (d_ack_d && (stat_d_cnt_q != 16'hFFFF)) begin
      stat_d_cnt_d = stat_d_cnt_q + 16'd1;
    end else begin
      stat_d_cnt_d = stat_d_cnt_q;
    end
    if (err_d && (stat_to_cnt_q != 8'hFF)) begin
      stat_to_cnt_d = stat_to_cnt_q + 8'd1;
    end else begin
      stat_to_cnt_d = stat_to_cnt_q;
    end
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b0;
      cnt_q         <= {CW{1'b0}};
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {AW{1'b0}};
      mem_wdata_q   <= {DW{1'b0}};
      if_rdata_q    <= {DW{1'b0}};
      d_rdata_q     <= {DW{1'b0}};
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
`ifdef HERA_ARB_STATS_EN
      stat_i_cnt_q  <= 16'd0;
      stat_d_cnt_q  <= 16'd0;
      stat_to_cnt_q <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_ack_q      <= if_ack_d;
      d_ack_q       <= d_ack_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
`ifdef HERA_ARB_STATS_EN
      stat_i_cnt_q  <= stat_i_cnt_d;
      stat_d_cnt_q  <= stat_d_cnt_d;
      stat_to_cnt_q <= stat_to_cnt_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign busy      = busy_q;
`ifdef HERA_ARB_STATS_EN
  assign stat_i_cnt  = stat_i_cnt_q;
  assign stat_d_cnt  = stat_d_cnt_q;
  assign stat_to_cnt = stat_to_cnt_q;
`endif

endmodule

// File: tb/tb_hera_mem_arbiter.sv
// Testbench for hera_mem_arbiter: a transaction-level reference model
// (owner / wait count / cool-down count) predicts the outputs every cycle,
// and directed scenarios pin the model with hand-computed literals.
module tb_hera_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ack, d_ack, mem_req, mem_we, busy, err;
`ifdef HERA_ARB_STATS_EN
  logic [15:0]   stat_i_cnt, stat_d_cnt;
  logic [7:0]    stat_to_cnt;
`endif

  hera_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err)
`ifdef HERA_ARB_STATS_EN
    , .stat_i_cnt(stat_i_cnt), .stat_d_cnt(stat_d_cnt), .stat_to_cnt(stat_to_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_active;     // a transaction owns the memory port
  bit            m_port_d;     // owner: 0 = I, 1 = D
  bit            m_last_d;     // last granted port: 0 = I, 1 = D
  int            m_waited;     // cycles waited without mem_ack
  int            m_cool;       // turnaround cycles still to elapse
  logic          e_mem_req, e_mem_we, e_if_ack, e_d_ack, e_err, e_busy;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_if_rdata, e_d_rdata;
  int            m_i_cnt, m_d_cnt, m_to_cnt;

  task automatic model_reset();
    m_active = 1'b0; m_port_d = 1'b0; m_last_d = 1'b0; m_waited = 0; m_cool = 0;
    e_mem_req = 1'b0; e_mem_we = 1'b0; e_if_ack = 1'b0; e_d_ack = 1'b0;
    e_err = 1'b0; e_busy = 1'b0; e_mem_addr = '0; e_mem_wdata = '0;
    e_if_rdata = '0; e_d_rdata = '0;
    m_i_cnt = 0; m_d_cnt = 0; m_to_cnt = 0;
  endtask

  task automatic model_finish(input bit aborted);
    logic [DW-1:0] data;
    data = (aborted || (m_port_d && e_mem_we)) ? 16'h0000 : mem_rdata;
    m_active = 1'b0; m_cool = 1; e_mem_req = 1'b0; e_busy = 1'b1; e_err = aborted;
    if (m_port_d) begin
      e_d_ack = 1'b1; e_d_rdata = data;
      if (m_d_cnt < 65535) m_d_cnt++;
    end else begin
      e_if_ack = 1'b1; e_if_rdata = data;
      if (m_i_cnt < 65535) m_i_cnt++;
    end
    if (aborted && m_to_cnt < 255) m_to_cnt++;
  endtask

  task automatic model_step();
    if (!rst) begin
      model_reset();
    end else begin
      e_if_ack = 1'b0; e_d_ack = 1'b0; e_err = 1'b0;
      if (m_active) begin
        if (mem_ack) model_finish(1'b0);
        else begin
          m_waited++;
          if (m_waited >= TIMEOUT) model_finish(1'b1);
        end
      end else if (m_cool > 0) begin
        m_cool--;
        e_busy = 1'b0;
      end else if (if_req || d_req) begin
        m_port_d = (if_req && d_req) ? !m_last_d : d_req;
        m_last_d = m_port_d;
        m_active = 1'b1; m_waited = 0; e_mem_req = 1'b1; e_busy = 1'b1;
        e_mem_addr  = m_port_d ? d_addr : if_addr;
        e_mem_we    = m_port_d ? d_we : 1'b0;
        e_mem_wdata = m_port_d ? d_wdata : 16'h0000;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", mem_req, e_mem_req);
      check("busy", busy, e_busy);
      check("if_ack", if_ack, e_if_ack);
      check("d_ack", d_ack, e_d_ack);
      check("err", err, e_err);
      check("if_rdata", if_rdata, e_if_rdata);
      check("d_rdata", d_rdata, e_d_rdata);
      if (e_mem_req) begin
        check("mem_addr", mem_addr, e_mem_addr);
        check("mem_we", mem_we, e_mem_we);
        if (e_mem_we) check("mem_wdata", mem_wdata, e_mem_wdata);
      end
`ifdef HERA_ARB_STATS_EN
      check("stat_i_cnt", stat_i_cnt, m_i_cnt);
      check("stat_d_cnt", stat_d_cnt, m_d_cnt);
      check("stat_to_cnt", stat_to_cnt, m_to_cnt);
`endif
    end
  end

  // ---------------- requesters and memory responder ----------------
  int              ack_delay;    // cycles after mem_req rise to ack; -1 = never
  int              age;
  bit              stray;
  logic [DW-1:0]   rdata_val;
  int              n_if, n_d, n_err, n_err_lone, req_high;
  logic [16:0]     gq[$];        // {mem_we, mem_addr} per grant
  logic [DW-1:0]   wq[$];        // mem_wdata per grant

  task automatic tick();
    @(negedge clk);
    if (if_ack) begin n_if++; if_req = 1'b0; end
    if (d_ack) begin n_d++; d_req = 1'b0; end
    if (err) begin
      n_err++;
      if (!(if_ack || d_ack)) n_err_lone++;
    end
    mem_ack = 1'b0;
    mem_rdata = rdata_val;
    if (mem_req) begin
      req_high++;
      age++;
      if (age == 1) begin gq.push_back({mem_we, mem_addr}); wq.push_back(mem_wdata); end
      if (age == ack_delay) mem_ack = 1'b1;
    end else begin
      age = 0;
    end
    if (stray) begin mem_ack = 1'b1; stray = 1'b0; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((if_req || d_req || busy) && n < 200);
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
  endtask

  logic [16:0] exp_g;

  initial begin
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    ack_delay = 2; age = 0; stray = 1'b0; rdata_val = '0;
    n_if = 0; n_d = 0; n_err = 0; n_err_lone = 0; req_high = 0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    rst = 1'b1;
    tick();

    // 1: single fetch, ack two cycles after mem_req rises
    rdata_val = 16'hA1B2; if_addr = 16'h0004; if_req = 1'b1;
    wait_idle();
    exp_g = {1'b0, 16'h0004};
    check("t1_grant", gq[0], exp_g);
    check("t1_if_acks", n_if, 1);
    check("t1_if_rdata", if_rdata, 16'hA1B2);
    check("t1_model_rdata", e_if_rdata, 16'hA1B2);
    check("t1_busy", busy, 0);
    check("t1_req_cycles", req_high, 2);

    // 2: contention, D wins first, then I; both again -> D again
    rdata_val = 16'h1234;
    d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h55AA; if_addr = 16'h0010;
    if_req = 1'b1; d_req = 1'b1;
    wait_idle();
    exp_g = {1'b1, 16'h0100};
    check("t2_first_D", gq[1], exp_g);
    check("t2_wdata", wq[1], 16'h55AA);
    exp_g = {1'b0, 16'h0010};
    check("t2_then_I", gq[2], exp_g);
    check("t2_store_rdata", d_rdata, 16'h0000);
    d_we = 1'b0; d_addr = 16'h0102; if_addr = 16'h0012;
    if_req = 1'b1; d_req = 1'b1;
    wait_idle();
    exp_g = {1'b0, 16'h0102};
    check("t2_D_again", gq[3], exp_g);
    exp_g = {1'b0, 16'h0012};
    check("t2_I_after", gq[4], exp_g);
    check("t2_load_rdata", d_rdata, 16'h1234);

    // 3: D load never acknowledged -> timeout abort
    ack_delay = -1; req_high = 0; n_d = 0; n_err = 0;
    d_we = 1'b0; d_addr = 16'h0200; d_req = 1'b1;
    wait_idle();
    check("t3_req_cycles", req_high, 15);
    check("t3_d_acks", n_d, 1);
    check("t3_err", n_err, 1);
    check("t3_err_alone", n_err_lone, 0);
    check("t3_d_rdata", d_rdata, 16'h0000);
    check("t3_model_rdata", e_d_rdata, 16'h0000);

    // 4: reset during GNT_I
    if_addr = 16'h0020; if_req = 1'b1; n_if = 0;
    repeat (4) tick();
    check("t4_req_before", mem_req, 1);
    rst = 1'b0; if_req = 1'b0;
    tick();
    check("t4_req_after", mem_req, 0);
    check("t4_busy_after", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    check("t4_no_ack", n_if, 0);
    ack_delay = 2; rdata_val = 16'hBEEF; if_addr = 16'h0030; if_req = 1'b1;
    wait_idle();
    check("t4_regrant_ack", n_if, 1);
    check("t4_regrant_rdata", if_rdata, 16'hBEEF);
    exp_g = {1'b0, 16'h0030};
    check("t4_regrant_addr", gq[gq.size()-1], exp_g);

    // 5: stray mem_ack while idle
    n_if = 0; n_d = 0; n_err = 0;
    stray = 1'b1;
    repeat (3) tick();
    check("t5_no_acks", n_if + n_d, 0);
    check("t5_no_err", n_err, 0);
    check("t5_idle", busy, 0);

    // 6: two more fetches and a D timeout (statistics)
    if_addr = 16'h0040; if_req = 1'b1;
    wait_idle();
    if_addr = 16'h0042; if_req = 1'b1;
    wait_idle();
    ack_delay = -1; d_addr = 16'h0300; d_req = 1'b1;
    wait_idle();
    check("t6_err", n_err, 1);
`ifdef HERA_ARB_STATS_EN
    check("t6_stat_i", stat_i_cnt, 3);
    check("t6_stat_d", stat_d_cnt, 1);
    check("t6_stat_to", stat_to_cnt, 1);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
